// File: rtl/io_port_responder_if.sv
// Data-bus bundle between the single-cycle MIPS core and the I/O responder.
// The core side drives the access; the responder answers combinationally.
interface io_port_responder_if;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Hit;

    modport master (
        output MemWrite, MemRead, Address, WriteData,
        input  ReadData, Hit
    );

    modport slave (
        input  MemWrite, MemRead, Address, WriteData,
        output ReadData, Hit
    );
endinterface

// File: rtl/io_port_responder.sv
// Memory-mapped I/O responder: PORT_OUT/PORT_IN registers, sticky status and a
// down-counter timer that is only built when the IO_TIMER_EN macro is defined.
module io_port_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0040,
    parameter int          TIMER_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    io_port_responder_if.slave  bus,
    input  logic [7:0]          PortIn,
    output logic [31:0]         PortOut,
    output logic                IRQ
);

    logic [31:0] port_out_q, port_out_d;
    logic [7:0]  sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [1:0]  status_q, status_d;
    logic        irq_q, irq_d;
    logic        hit, we;
    logic [2:0]  offset;
    logic [31:0] rdata;
    logic        expire;
    logic [31:0] load_rd, count_rd, ctrl_rd;
    logic        unused_addr_lsbs;

    assign hit              = (bus.Address[31:5] == BASE_ADDR[31:5]);
    assign offset           = bus.Address[4:2];
    assign we               = bus.MemWrite & hit;
    assign unused_addr_lsbs = ^bus.Address[1:0];

`ifdef IO_TIMER_EN
    logic [TIMER_WIDTH-1:0] load_q, load_d, count_q, count_d;
    logic [1:0]             ctrl_q, ctrl_d;

    always_comb begin
        load_d  = load_q;
        count_d = count_q;
        ctrl_d  = ctrl_q;
        expire  = 1'b0;
        if (ctrl_q[0] && (count_q != '0)) begin
            if (count_q == TIMER_WIDTH'(1)) begin
                expire  = 1'b1;
                count_d = ctrl_q[1] ? load_q : '0;
            end else begin
                count_d = count_q - TIMER_WIDTH'(1);
            end
        end
        // A software reload beats the hardware count update on the same edge.
        if (we && (offset == 3'd3)) begin
            load_d  = bus.WriteData[TIMER_WIDTH-1:0];
            count_d = bus.WriteData[TIMER_WIDTH-1:0];
        end
        if (we && (offset == 3'd5)) begin
            ctrl_d = bus.WriteData[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_q  <= '0;
            count_q <= '0;
            ctrl_q  <= '0;
        end else begin
            load_q  <= load_d;
            count_q <= count_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign load_rd  = 32'(load_q);
    assign count_rd = 32'(count_q);
    assign ctrl_rd  = {30'b0, ctrl_q};
`else
    localparam int unused_timer_width = TIMER_WIDTH;

    assign expire   = 1'b0;
    assign load_rd  = 32'b0;
    assign count_rd = 32'b0;
    assign ctrl_rd  = 32'b0;
`endif

    always_comb begin
        port_out_d = port_out_q;
        sync1_d    = PortIn;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        status_d   = status_q;
        if (we && (offset == 3'd0)) begin
            port_out_d = bus.WriteData;
        end
        if (we && (offset == 3'd2)) begin
            status_d = status_q & ~bus.WriteData[1:0];
        end
        // Hardware sets are applied after the W1C so they win a same-edge clear.
        if (sync2_q != prev_q) begin
            status_d[0] = 1'b1;
        end
        if (expire) begin
            status_d[1] = 1'b1;
        end
        irq_d = |status_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            port_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            status_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            port_out_q <= port_out_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            status_q   <= status_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        rdata = 32'b0;
        if (bus.MemRead && hit) begin
            case (offset)
                3'd0:    rdata = port_out_q;
                3'd1:    rdata = {24'b0, sync2_q};
                3'd2:    rdata = {30'b0, status_q};
                3'd3:    rdata = load_rd;
                3'd4:    rdata = count_rd;
                3'd5:    rdata = ctrl_rd;
                default: rdata = 32'b0;
            endcase
        end
    end

    assign bus.ReadData = rdata;
    assign bus.Hit      = hit;
    assign PortOut      = port_out_q;
    assign IRQ          = irq_q;

endmodule

// File: tb/tb_io_port_responder.sv
// Self-checking bench for io_port_responder; expected read data is queued when
// each access is issued and popped when the combinational response is sampled.
module tb_io_port_responder;
    localparam logic [31:0] BASE = 32'h1001_0040;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  port_in;
    logic [31:0] port_out;
    logic        irq;

    io_port_responder_if bif();

    io_port_responder #(
        .BASE_ADDR  (BASE),
        .TIMER_WIDTH(32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bif),
        .PortIn (port_in),
        .PortOut(port_out),
        .IRQ    (irq)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd;
    logic [31:0] exp_v;
    logic        hit;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_idle();
        bif.MemWrite  = 1'b0;
        bif.MemRead   = 1'b0;
        bif.Address   = 32'h0;
        bif.WriteData = 32'h0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bif.MemWrite  = 1'b1;
        bif.Address   = a;
        bif.WriteData = d;
        tick(1);
        bif.MemWrite  = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
        bif.MemRead = 1'b1;
        bif.Address = a;
        #1;
        d = bif.ReadData;
        h = bif.Hit;
        bif.MemRead = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] offs[3];
        offs = '{32'h0, 32'h4, 32'h8};
        reset   = 1'b1;
        port_in = 8'h00;
        bus_idle();
        tick(3);
        reset = 1'b0;
        total++; if (port_out !== 32'h0) begin bad++; $display("FAIL reset_portout got=%h want=%h", port_out, 32'h0); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < 3; i++) begin
            bus_read(BASE + offs[i], rd, hit);
            exp_v = exp_q.pop_front();
            total++; if (rd !== exp_v) begin bad++; $display("FAIL reset_read off=%h got=%h want=%h", offs[i], rd, exp_v); end
            total++; if (hit !== 1'b1) begin bad++; $display("FAIL reset_hit off=%h got=%b want=1", offs[i], hit); end
        end
    endtask

    task automatic test_port_out();
        bus_write(BASE, 32'hA5A5_0F0F);
        total++; if (port_out !== 32'hA5A5_0F0F) begin bad++; $display("FAIL portout_pin got=%h want=%h", port_out, 32'hA5A5_0F0F); end
        exp_q.push_back(32'hA5A5_0F0F);
        bus_read(BASE, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL portout_read got=%h want=%h", rd, exp_v); end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        total++; if (port_out !== 32'h0) begin bad++; $display("FAIL portout_reset got=%h want=%h", port_out, 32'h0); end
        // Reset must override a store on the same edge.
        reset = 1'b1;
        bus_write(BASE, 32'h1234_5678);
        reset = 1'b0;
        total++; if (port_out !== 32'h0) begin bad++; $display("FAIL portout_reset_wr got=%h want=%h", port_out, 32'h0); end
        bus_write(BASE, 32'hDEAD_BEEF);
        exp_q.push_back(32'hDEAD_BEEF);
        bus_read(BASE, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL portout_read2 got=%h want=%h", rd, exp_v); end
    endtask

    task automatic test_port_in();
        port_in = 8'h3C;
        tick(1);
        exp_q.push_back(32'h0);
        bus_read(BASE + 32'h4, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL portin_early got=%h want=%h", rd, exp_v); end
        tick(1);
        exp_q.push_back(32'h3C);
        exp_q.push_back(32'h0);
        bus_read(BASE + 32'h4, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL portin_read got=%h want=%h", rd, exp_v); end
        bus_read(BASE + 32'h8, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL portin_status_early got=%h want=%h", rd, exp_v); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL portin_irq_early got=%b want=0", irq); end
        tick(1);
        exp_q.push_back(32'h1);
        bus_read(BASE + 32'h8, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL portin_status_set got=%h want=%h", rd, exp_v); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL portin_irq_set got=%b want=1", irq); end
        // Writing a 0 bit must not clear it; writing 1 clears.
        bus_write(BASE + 32'h8, 32'h2);
        exp_q.push_back(32'h1);
        bus_read(BASE + 32'h8, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL portin_w1c_other got=%h want=%h", rd, exp_v); end
        bus_write(BASE + 32'h8, 32'h1);
        exp_q.push_back(32'h0);
        bus_read(BASE + 32'h8, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL portin_w1c got=%h want=%h", rd, exp_v); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL portin_irq_clr got=%b want=0", irq); end
        // Clear lands on the same edge as a new input change: the set wins.
        port_in = 8'h3D;
        tick(2);
        bus_write(BASE + 32'h8, 32'h1);
        exp_q.push_back(32'h1);
        bus_read(BASE + 32'h8, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL portin_set_wins got=%h want=%h", rd, exp_v); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL portin_set_wins_irq got=%b want=1", irq); end
        bus_write(BASE + 32'h8, 32'h1);
        exp_q.push_back(32'h0);
        bus_read(BASE + 32'h8, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL portin_clr2 got=%h want=%h", rd, exp_v); end
    endtask

    task automatic test_window();
        logic [31:0] outside[2];
        outside = '{BASE + 32'h20, 32'h1001_0000};
        for (int i = 0; i < 2; i++) begin
            bif.MemWrite  = 1'b1;
            bif.Address   = outside[i];
            bif.WriteData = 32'hFFFF_FFFF;
            #1;
            total++; if (bif.Hit !== 1'b0) begin bad++; $display("FAIL window_hit addr=%h got=%b want=0", outside[i], bif.Hit); end
            tick(1);
            bif.MemWrite = 1'b0;
            total++; if (port_out !== 32'hDEAD_BEEF) begin bad++; $display("FAIL window_portout addr=%h got=%h want=%h", outside[i], port_out, 32'hDEAD_BEEF); end
        end
        exp_q.push_back(32'h0);
        bus_read(BASE + 32'h20, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL window_read_out got=%h want=%h", rd, exp_v); end
        bus_write(BASE + 32'h18, 32'h5555_AAAA);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        bus_read(BASE + 32'h18, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL window_read_18 got=%h want=%h", rd, exp_v); end
        total++; if (hit !== 1'b1) begin bad++; $display("FAIL window_hit_18 got=%b want=1", hit); end
        bus_read(BASE + 32'h1C, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL window_read_1c got=%h want=%h", rd, exp_v); end
        bus_read(BASE - 32'h4, rd, hit);
        total++; if (hit !== 1'b0) begin bad++; $display("FAIL window_hit_below got=%b want=0", hit); end
        // Hit with no MemRead must still return zero data.
        bif.MemRead = 1'b0;
        bif.Address = BASE;
        #1;
        total++; if (bif.ReadData !== 32'h0) begin bad++; $display("FAIL window_noread got=%h want=%h", bif.ReadData, 32'h0); end
        total++; if (bif.Hit !== 1'b1) begin bad++; $display("FAIL window_noread_hit got=%b want=1", bif.Hit); end
        exp_q.push_back(32'hDEAD_BEEF);
        bus_read(BASE, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL window_portout_read got=%h want=%h", rd, exp_v); end
    endtask

`ifdef IO_TIMER_EN
    task automatic test_timer();
        logic [31:0] cnt_seq[7];
        cnt_seq = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
        bus_write(BASE + 32'h14, 32'h1);
        bus_write(BASE + 32'h0C, 32'd5);
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(cnt_seq[i]);
            exp_q.push_back((i >= 5) ? 32'h2 : 32'h0);
        end
        for (int i = 0; i < 7; i++) begin
            bus_read(BASE + 32'h10, rd, hit);
            exp_v = exp_q.pop_front();
            total++; if (rd !== exp_v) begin bad++; $display("FAIL timer_count i=%0d got=%h want=%h", i, rd, exp_v); end
            bus_read(BASE + 32'h8, rd, hit);
            exp_v = exp_q.pop_front();
            total++; if (rd !== exp_v) begin bad++; $display("FAIL timer_status i=%0d got=%h want=%h", i, rd, exp_v); end
            tick(1);
        end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL timer_irq got=%b want=1", irq); end
        bus_write(BASE + 32'h8, 32'h3);
        bus_write(BASE + 32'h14, 32'h3);
        bus_write(BASE + 32'h0C, 32'd3);
        tick(2);
        exp_q.push_back(32'd1);
        bus_read(BASE + 32'h10, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL auto_count1 got=%h want=%h", rd, exp_v); end
        tick(1);
        exp_q.push_back(32'h2);
        exp_q.push_back(32'd3);
        bus_read(BASE + 32'h8, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL auto_expire1 got=%h want=%h", rd, exp_v); end
        bus_read(BASE + 32'h10, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL auto_reload got=%h want=%h", rd, exp_v); end
        bus_write(BASE + 32'h8, 32'h2);
        exp_q.push_back(32'h0);
        bus_read(BASE + 32'h8, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL auto_clear got=%h want=%h", rd, exp_v); end
        tick(1);
        // This clear coincides with the second expiry.
        bus_write(BASE + 32'h8, 32'h2);
        exp_q.push_back(32'h2);
        exp_q.push_back(32'd3);
        bus_read(BASE + 32'h8, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL auto_set_wins got=%h want=%h", rd, exp_v); end
        bus_read(BASE + 32'h10, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL auto_reload2 got=%h want=%h", rd, exp_v); end
        bus_write(BASE + 32'h14, 32'h0);
        tick(3);
        exp_q.push_back(32'd2);
        bus_read(BASE + 32'h10, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL timer_frozen got=%h want=%h", rd, exp_v); end
        bus_write(BASE + 32'h14, 32'h1);
        bus_write(BASE + 32'h0C, 32'd7);
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd7);
        bus_read(BASE + 32'h10, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL timer_load_prio got=%h want=%h", rd, exp_v); end
        bus_read(BASE + 32'h0C, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL timer_load_read got=%h want=%h", rd, exp_v); end
        bus_write(BASE + 32'h8, 32'h3);
        bus_write(BASE + 32'h0C, 32'd0);
        tick(10);
        exp_q.push_back(32'h0);
        bus_read(BASE + 32'h8, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL timer_load0 got=%h want=%h", rd, exp_v); end
    endtask
`else
    task automatic test_no_timer();
        logic [31:0] offs[3];
        offs = '{32'h0C, 32'h10, 32'h14};
        bus_write(BASE + 32'h14, 32'h3);
        bus_write(BASE + 32'h0C, 32'd2);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < 3; i++) begin
            bus_read(BASE + offs[i], rd, hit);
            exp_v = exp_q.pop_front();
            total++; if (rd !== exp_v) begin bad++; $display("FAIL notimer_read off=%h got=%h want=%h", offs[i], rd, exp_v); end
        end
        tick(6);
        exp_q.push_back(32'h0);
        bus_read(BASE + 32'h8, rd, hit);
        exp_v = exp_q.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL notimer_status got=%h want=%h", rd, exp_v); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL notimer_irq got=%b want=0", irq); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_port_out();
        test_port_in();
        test_window();
`ifdef IO_TIMER_EN
        test_timer();
`else
        test_no_timer();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
